// File: rtl/axi_aw_arbiter_if.sv
// ============================================================================
// Module   : axi_aw_arbiter_if
// Purpose  : AXI4 write-address channel bundle (addr/len/size/burst/valid/ready)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface axi_aw_arbiter_if #(
  parameter int ADDR_WIDTH = 12
);
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [7:0]            awlen;
  logic [2:0]            awsize;
  logic [1:0]            awburst;
  logic                  awvalid;
  logic                  awready;

  // Issuer of AW transactions
  modport master (
    output awaddr, awlen, awsize, awburst, awvalid,
    input  awready
  );

  // Acceptor of AW transactions
  modport slave (
    input  awaddr, awlen, awsize, awburst, awvalid,
    output awready
  );
endinterface

`default_nettype wire

// File: rtl/axi_aw_arbiter.sv
// ============================================================================
// Module   : axi_aw_arbiter
// Purpose  : Round-robin AW arbiter for two masters with an in-order grant FIFO
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_aw_arbiter #(
  parameter int ADDR_WIDTH  = 12,
  parameter int ORDER_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  axi_aw_arbiter_if.slave              s0,
  axi_aw_arbiter_if.slave              s1,
  axi_aw_arbiter_if.master             m,
  output logic                         o_order_id,
  output logic                         o_order_valid,
  input  logic                         i_order_pop,
  output logic [$clog2(ORDER_DEPTH):0] o_outstanding
);

  localparam int                 c_PTR_W = $clog2(ORDER_DEPTH);
  localparam logic [c_PTR_W:0]   c_DEPTH = (c_PTR_W + 1)'(ORDER_DEPTH);

  localparam logic [0:0] c_IDLE  = 1'b0;
  localparam logic [0:0] c_GRANT = 1'b1;

  if ((ORDER_DEPTH < 2) || ((ORDER_DEPTH & (ORDER_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("ORDER_DEPTH must be a power of two and at least 2");
  end

  logic [0:0]             r_state;
  logic                   r_sel;
  logic                   r_last_grant;
  logic [ORDER_DEPTH-1:0] r_fifo;
  logic [c_PTR_W-1:0]     r_rd_ptr;
  logic [c_PTR_W-1:0]     r_wr_ptr;
  logic [c_PTR_W:0]       r_count;

  logic [0:0]             w_state_nxt;
  logic                   w_sel_nxt;
  logic                   w_pick;
  logic                   w_any_req;
  logic                   w_full;
  logic                   w_granting;
  logic                   w_sel_valid;
  logic                   w_push;
  logic                   w_pop;

  assign w_any_req   = s0.awvalid | s1.awvalid;
  assign w_full      = (r_count == c_DEPTH);
  assign w_granting  = (r_state == c_GRANT);
  assign w_sel_valid = r_sel ? s1.awvalid : s0.awvalid;

  // Tie goes to whichever master did not win last; last_grant resets to 1 so s0 wins first
  always_comb begin
    w_pick = 1'b0;
    if (s0.awvalid && s1.awvalid) begin
      w_pick = ~r_last_grant;
    end else if (s1.awvalid) begin
      w_pick = 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    case (r_state)
      c_IDLE: begin
        if (!w_full && w_any_req) begin
          w_state_nxt = c_GRANT;
          w_sel_nxt   = w_pick;
        end
      end
      c_GRANT: begin
        if (w_push) begin
          w_state_nxt = c_IDLE;
        end
      end
      default: begin
        w_state_nxt = c_IDLE;
      end
    endcase
  end

  // Downstream fields follow the locked selection; ready is a pure pass-through
  assign m.awaddr   = r_sel ? s1.awaddr  : s0.awaddr;
  assign m.awlen    = r_sel ? s1.awlen   : s0.awlen;
  assign m.awsize   = r_sel ? s1.awsize  : s0.awsize;
  assign m.awburst  = r_sel ? s1.awburst : s0.awburst;
  assign m.awvalid  = w_granting & w_sel_valid;
  assign s0.awready = w_granting & ~r_sel & m.awready;
  assign s1.awready = w_granting &  r_sel & m.awready;

  assign w_push = w_granting & m.awvalid & m.awready;
  assign w_pop  = i_order_pop & (r_count != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= c_IDLE;
      r_sel        <= 1'b0;
      r_last_grant <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      if (w_push) begin
        r_last_grant <= r_sel;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fifo   <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_fifo[r_wr_ptr] <= r_sel;
        r_wr_ptr         <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_order_id    = r_fifo[r_rd_ptr];
  assign o_order_valid = (r_count != '0);
  assign o_outstanding = r_count;

  a_count_bound: assert property (@(posedge clk) r_count <= c_DEPTH);

  a_one_ready: assert property (@(posedge clk) !(s0.awready && s1.awready));

  a_hold_stable: assert property (@(posedge clk)
    (!reset && m.awvalid && !m.awready) |=>
      (reset || ($stable(m.awaddr) && $stable(m.awlen) && $stable(m.awsize) &&
                 $stable(m.awburst) && m.awvalid)));

  a_idle_after_reset: assert property (@(posedge clk) reset |=> !m.awvalid);

  // A granted master withdrawing valid before its handshake breaks AXI ordering rules
  a_grant_held: assert property (@(posedge clk) (!reset && w_granting) |-> w_sel_valid);

  a_pop_nonempty: assert property (@(posedge clk) (!reset && i_order_pop) |-> (r_count != '0));

endmodule

`default_nettype wire

// File: tb/tb_axi_aw_arbiter.sv
// ============================================================================
// Module   : tb_axi_aw_arbiter
// Purpose  : Directed self-checking bench for axi_aw_arbiter
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axi_aw_arbiter;

  logic       clk;
  logic       reset;
  logic       i_order_pop;
  logic       o_order_id;
  logic       o_order_valid;
  logic [2:0] o_outstanding;

  int n_checks;
  int n_fail;

  axi_aw_arbiter_if #(.ADDR_WIDTH(12)) s0_if ();
  axi_aw_arbiter_if #(.ADDR_WIDTH(12)) s1_if ();
  axi_aw_arbiter_if #(.ADDR_WIDTH(12)) m_if ();

  axi_aw_arbiter #(
    .ADDR_WIDTH  (12),
    .ORDER_DEPTH (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .s0            (s0_if),
    .s1            (s1_if),
    .m             (m_if),
    .o_order_id    (o_order_id),
    .o_order_valid (o_order_valid),
    .i_order_pop   (i_order_pop),
    .o_outstanding (o_outstanding)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    s0_if.awvalid = 1'b0; s0_if.awaddr = '0; s0_if.awlen = '0; s0_if.awsize = '0; s0_if.awburst = '0;
    s1_if.awvalid = 1'b0; s1_if.awaddr = '0; s1_if.awlen = '0; s1_if.awsize = '0; s1_if.awburst = '0;
    m_if.awready  = 1'b0;
    i_order_pop   = 1'b0;
  endtask

  task automatic do_reset();
    step();
    reset = 1'b1;
    clear_inputs();
    step();
    step();
    check("rst_m_awvalid",   32'(m_if.awvalid),  32'h0);
    check("rst_s0_awready",  32'(s0_if.awready), 32'h0);
    check("rst_s1_awready",  32'(s1_if.awready), 32'h0);
    check("rst_order_valid", 32'(o_order_valid), 32'h0);
    check("rst_outstanding", 32'(o_outstanding), 32'h0);
    reset = 1'b0;
  endtask

  // One full AW transaction from a single master with m_awready high
  task automatic send(input bit port, input logic [11:0] addr, input logic [7:0] len, input bit pop_in_grant);
    step();
    if (port) begin
      s1_if.awvalid = 1'b1; s1_if.awaddr = addr; s1_if.awlen = len; s1_if.awsize = 3'd2; s1_if.awburst = 2'd1;
    end else begin
      s0_if.awvalid = 1'b1; s0_if.awaddr = addr; s0_if.awlen = len; s0_if.awsize = 3'd2; s0_if.awburst = 2'd1;
    end
    m_if.awready = 1'b1;
    #1;
    check("send_idle_valid", 32'(m_if.awvalid), 32'h0);
    check("send_idle_ready", 32'(port ? s1_if.awready : s0_if.awready), 32'h0);
    step();
    i_order_pop = pop_in_grant;
    #1;
    check("send_grant_valid", 32'(m_if.awvalid), 32'h1);
    check("send_grant_addr",  32'(m_if.awaddr),  32'(addr));
    check("send_grant_len",   32'(m_if.awlen),   32'(len));
    check("send_grant_rdy",   32'(port ? s1_if.awready : s0_if.awready), 32'h1);
    check("send_other_rdy",   32'(port ? s0_if.awready : s1_if.awready), 32'h0);
    step();
    if (port) s1_if.awvalid = 1'b0;
    else      s0_if.awvalid = 1'b0;
    i_order_pop = 1'b0;
    #1;
    check("send_after_valid", 32'(m_if.awvalid), 32'h0);
    check("send_after_rdy",   32'(port ? s1_if.awready : s0_if.awready), 32'h0);
  endtask

  initial begin
    int grants;
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    clear_inputs();

    // Single s0 transaction
    do_reset();
    send(1'b0, 12'h100, 8'd3, 1'b0);
    check("t1_order_id",    32'(o_order_id),    32'h0);
    check("t1_order_valid", 32'(o_order_valid), 32'h1);
    check("t1_outstanding", 32'(o_outstanding), 32'h1);
    step(); i_order_pop = 1'b1;
    step(); i_order_pop = 1'b0; #1;
    check("t1_drained", 32'(o_outstanding), 32'h0);

    // Both masters continuously valid: alternate 0,1,0,1 with a bubble between grants
    do_reset();
    for (int k = 0; k < 8; k++) begin
      step();
      if (k == 0) begin
        s0_if.awvalid = 1'b1; s0_if.awaddr = 12'h200; s0_if.awlen = 8'd1;
        s1_if.awvalid = 1'b1; s1_if.awaddr = 12'h300; s1_if.awlen = 8'd2;
        m_if.awready  = 1'b1;
      end
      i_order_pop = (k >= 2) && (k % 2 == 0);
      #1;
      if (k % 2 == 1) begin
        check("t2_grant_valid", 32'(m_if.awvalid), 32'h1);
        check("t2_grant_addr",  32'(m_if.awaddr), (((k >> 1) & 1) == 1) ? 32'h300 : 32'h200);
        check("t2_grant_rdy",   32'((((k >> 1) & 1) == 1) ? s1_if.awready : s0_if.awready), 32'h1);
      end else begin
        check("t2_bubble_valid", 32'(m_if.awvalid), 32'h0);
        if (k >= 2) check("t2_fifo_id", 32'(o_order_id), 32'(((k >> 1) - 1) & 1));
      end
    end
    step();
    s0_if.awvalid = 1'b0; s1_if.awvalid = 1'b0; i_order_pop = 1'b1; #1;
    check("t2_last_id",  32'(o_order_id),    32'h1);
    check("t2_last_cnt", 32'(o_outstanding), 32'h1);
    step(); i_order_pop = 1'b0; #1;
    check("t2_drained", 32'(o_outstanding), 32'h0);

    // s1 stalled by m_awready=0 for five cycles
    do_reset();
    step();
    s1_if.awvalid = 1'b1; s1_if.awaddr = 12'h3A4; s1_if.awlen = 8'd7; s1_if.awsize = 3'd3; s1_if.awburst = 2'd2;
    m_if.awready = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      step(); #1;
      check("t3_stall_valid", 32'(m_if.awvalid),  32'h1);
      check("t3_stall_addr",  32'(m_if.awaddr),   32'h3A4);
      check("t3_stall_len",   32'(m_if.awlen),    32'h7);
      check("t3_stall_s0rdy", 32'(s0_if.awready), 32'h0);
      check("t3_stall_cnt",   32'(o_outstanding), 32'h0);
    end
    step(); m_if.awready = 1'b1; #1;
    check("t3_size",   32'(m_if.awsize),   32'h3);
    check("t3_burst",  32'(m_if.awburst),  32'h2);
    check("t3_s1rdy",  32'(s1_if.awready), 32'h1);
    check("t3_s0rdy",  32'(s0_if.awready), 32'h0);
    step(); s1_if.awvalid = 1'b0; #1;
    check("t3_cnt", 32'(o_outstanding), 32'h1);
    check("t3_id",  32'(o_order_id),    32'h1);
    step(); i_order_pop = 1'b1;
    step(); i_order_pop = 1'b0; #1;
    check("t3_drained", 32'(o_outstanding), 32'h0);

    // FIFO fills with no pops; one pop releases a fifth grant
    do_reset();
    step();
    s0_if.awvalid = 1'b1; s0_if.awaddr = 12'h040; m_if.awready = 1'b1;
    #1;
    grants = 0;
    for (int i = 0; i < 12; i++) begin
      step(); #1;
      if (s0_if.awready && m_if.awvalid) grants++;
    end
    check("t4_grants",    32'(grants),         32'h4);
    check("t4_full_cnt",  32'(o_outstanding),  32'h4);
    check("t4_full_vld",  32'(m_if.awvalid),   32'h0);
    check("t4_full_rdy",  32'(s0_if.awready),  32'h0);
    step(); i_order_pop = 1'b1; #1;
    check("t4_pop_vld", 32'(m_if.awvalid), 32'h0);
    step(); i_order_pop = 1'b0; #1;
    check("t4_cnt3",     32'(o_outstanding), 32'h3);
    check("t4_idle_vld", 32'(m_if.awvalid),  32'h0);
    step(); #1;
    check("t4_fifth_vld", 32'(m_if.awvalid),  32'h1);
    check("t4_fifth_rdy", 32'(s0_if.awready), 32'h1);
    step(); s0_if.awvalid = 1'b0; #1;
    check("t4_refull", 32'(o_outstanding), 32'h4);

    // Push and pop in the same cycle
    do_reset();
    send(1'b1, 12'h010, 8'd0, 1'b0);
    send(1'b0, 12'h020, 8'd1, 1'b0);
    check("t5_cnt2",  32'(o_outstanding), 32'h2);
    check("t5_head1", 32'(o_order_id),    32'h1);
    send(1'b1, 12'h030, 8'd2, 1'b1);
    check("t5_cnt_same", 32'(o_outstanding), 32'h2);
    check("t5_head0",    32'(o_order_id),    32'h0);
    step(); i_order_pop = 1'b1; #1;
    check("t5_pop_a", 32'(o_order_id), 32'h0);
    step(); i_order_pop = 1'b1; #1;
    check("t5_pop_b",     32'(o_order_id),    32'h1);
    check("t5_pop_b_cnt", 32'(o_outstanding), 32'h1);
    step(); i_order_pop = 1'b0; #1;
    check("t5_drained", 32'(o_outstanding), 32'h0);

    // Reset while a grant is stalled; the tie afterwards goes to s0
    do_reset();
    step();
    s1_if.awvalid = 1'b1; s1_if.awaddr = 12'h0F0; m_if.awready = 1'b0;
    #1;
    step(); #1;
    check("t6_grant_s1", 32'(m_if.awvalid), 32'h1);
    step(); reset = 1'b1; #1;
    step();
    reset = 1'b0;
    s0_if.awvalid = 1'b1; s0_if.awaddr = 12'h0A0; m_if.awready = 1'b1;
    #1;
    check("t6_rst_vld", 32'(m_if.awvalid),  32'h0);
    check("t6_rst_cnt", 32'(o_outstanding), 32'h0);
    step(); #1;
    check("t6_tie_addr", 32'(m_if.awaddr),   32'h0A0);
    check("t6_tie_rdy",  32'(s0_if.awready), 32'h1);
    step(); s0_if.awvalid = 1'b0; #1;
    check("t6_cnt1", 32'(o_outstanding), 32'h1);
    check("t6_id0",  32'(o_order_id),    32'h0);
    step(); #1;
    check("t6_s1_addr", 32'(m_if.awaddr),   32'h0F0);
    check("t6_s1_rdy",  32'(s1_if.awready), 32'h1);
    step(); s1_if.awvalid = 1'b0; #1;
    check("t6_cnt2", 32'(o_outstanding), 32'h2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/axi_aw_arbiter.md
Name: axi_aw_arbiter

Overview:
- Shares one `axi_addr_counter` AW input between two AXI4 write masters (s0, s1).
- Grants whole AW transactions with round-robin arbitration.
- Records each granted master's index in an in-order grant FIFO. Downstream W-data / B-response muxing consumes this FIFO to route beats and responses back to the right master.

Parameters:
- ADDR_WIDTH, 12, AW address width; must match `axi_addr_counter`.
- ORDER_DEPTH, 4, grant FIFO entries (power of 2, ≥2); limits outstanding bursts.

Ports:
- clk  in  1  single clock
- reset  in  1  synchronous, active-high reset
- s0_awaddr  in  ADDR_WIDTH  master 0 AW address
- s0_awlen  in  8  master 0 burst length − 1
- s0_awsize  in  3  master 0 beat size
- s0_awburst  in  2  master 0 burst type
- s0_awvalid  in  1  master 0 AW valid
- s0_awready  out  1  master 0 AW ready
- s1_awaddr, s1_awlen, s1_awsize, s1_awburst, s1_awvalid, s1_awready: same as s0, master 1
- m_awaddr  out  ADDR_WIDTH  to `axi_addr_counter` `i_awaddr`
- m_awlen  out  8  to `i_awlen`
- m_awsize  out  3  to `i_awsize`
- m_awburst  out  2  to `i_awburst`
- m_awvalid  out  1  to `i_awvalid`
- m_awready  in  1  from `i_awready`
- o_order_id  out  1  master index at FIFO head
- o_order_valid  out  1  FIFO not empty
- i_order_pop  in  1  consumer retires head entry (final B of that burst)
- o_outstanding  out  $clog2(ORDER_DEPTH)+1  FIFO occupancy

Behaviour:
- FSM states: IDLE, GRANT. Registers:
  - sel (1 bit)
  - last_grant (1 bit)
  - FIFO storage, rd_ptr, wr_ptr, count
- Reset (synchronous, dominates all else):
  - state=IDLE, sel=0, last_grant=1 (so s0 wins first tie), rd_ptr=wr_ptr=count=0.
  - Outputs: m_awvalid=0, s0_awready=s1_awready=0, o_order_valid=0, o_outstanding=0.
- IDLE:
  - All readies 0; m_awvalid=0.
  - If count<ORDER_DEPTH and any sN_awvalid: pick the requester.
    - Only one valid: pick it.
    - Both valid: pick ~last_grant.
  - Register choice into sel; next state GRANT.
  - If FIFO full: stay IDLE regardless of requests.
- GRANT:
  - m_aw* fields combinationally muxed from port sel.
  - m_awvalid = s[sel]_awvalid.
  - s[sel]_awready = m_awready; the other port's ready = 0.
  - On m_awvalid && m_awready:
    - push sel into FIFO at wr_ptr;
    - last_grant<=sel;
    - next state IDLE.
  - Otherwise stay in GRANT.
  - Grant is locked until handshake. Dropping s[sel]_awvalid without handshake is an AXI violation: flagged by assertion; FSM stays in GRANT.
- Latency: request to m_awvalid is 1 cycle (IDLE decision registered). Minimum 2 cycles per AW transaction; one bubble between consecutive grants.
- No combinational path from sN_awvalid to sN_awready. m_awready→s[sel]_awready is combinational pass-through.
- Fields are passed through unmodified. Burst/size/alignment legality is checked downstream by `axi_addr_counter`.
- FIFO:
  - Pop occurs when i_order_pop && count>0.
  - Pop with count==0 is ignored; assertion fires.
  - Simultaneous push and pop: count unchanged; both pointers advance.
  - Push never occurs when full, because GRANT is entered only with count<ORDER_DEPTH and only pops occur meanwhile.
  - Pointers wrap modulo ORDER_DEPTH.
  - o_order_id = storage[rd_ptr]; o_order_valid = count!=0; o_outstanding = count.
- Reset mid-GRANT: the pending transaction is abandoned (not pushed); upstream re-presents it after reset.
- Formal:
  - assert count<=ORDER_DEPTH;
  - assert never both sN_awready=1;
  - assert m_aw* stable while m_awvalid && !m_awready;
  - assert m_awvalid=0 the cycle after reset.

Test Plan:
- Only s0 valid, addr=0x100, len=3, m_awready=1 → m_awvalid cycle 2 with m_awaddr=0x100, m_awlen=3; s0_awready pulses once; o_order_id=0, o_outstanding=1.
- s0 and s1 both continuously valid, m_awready=1, consumer popping each cycle → grant order 0,1,0,1; m_awvalid high every other cycle; FIFO ids match order.
- s1 valid, m_awready held 0 for 5 cycles then 1 → m_awaddr/len stable for 5 cycles, s0_awready=0 throughout, exactly one push of id 1.
- No pops, s0 valid continuously, ORDER_DEPTH=4 → exactly 4 grants, o_outstanding=4, FSM idles with s0_awready=0. One i_order_pop → fifth grant issued.
- FIFO count=2, pop and handshake in the same cycle → o_outstanding stays 2, head advances to next id.
- Reset asserted during GRANT with m_awready=0 → next cycle m_awvalid=0, o_outstanding=0, next tie goes to s0.
